// File: rtl/alu181_pkg.sv
// alu181_pkg: shared types and constants for the sequential 74181-style ALU.
//   state_t   - controller states (IDLE, RUN, DONE)
//   SLICE_W   - width of the shared combinational slice
//   S_*       - commonly used function-select codes (74181 encoding)
//   g_merge_n - folds one slice's group generate/propagate into the running
//               active-low group generate
package alu181_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    localparam logic [3:0] S_ADD = 4'b1001;  // m=0: A plus B
    localparam logic [3:0] S_SUB = 4'b0110;  // m=0: A minus B minus 1 (cn=1)
    localparam logic [3:0] S_XOR = 4'b0110;  // m=1: A xor B
    localparam logic [3:0] S_AND = 4'b1011;  // m=1: A and B
    localparam logic [3:0] S_OR  = 4'b1110;  // m=1: A or B

    // The group generates when the newest slice generates, or when it
    // propagates and the lower slices already generated (all active-low).
    function automatic logic g_merge_n(input logic g_slice_n,
                                       input logic p_slice_n,
                                       input logic g_acc_n);
        return g_slice_n & (p_slice_n | g_acc_n);
    endfunction

endpackage

// File: rtl/alu181_slice.sv
// alu181_slice: purely combinational 4-bit 74181 equivalent, active-high data.
//   a, b : 4-bit operands        s  : function select
//   m    : 1 = logic, 0 = arith  cn : carry-in, active-low
//   f    : result                aeb: f is all ones
//   cn4  : carry-out, active-low p_n/g_n: group propagate/generate, active-low
module alu181_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       aeb,
    output logic       cn4,
    output logic       p_n,
    output logic       g_n
);

    logic [3:0] prop_s;
    logic [3:0] gen_s;
    logic [4:0] carry_s;  // active-high internal carry into each bit

    // Per-bit propagate/generate chosen by s, ripple carry and result bits.
    // gen^prop is the half-sum; m forces the carry term high so logic mode
    // yields the complemented half-sum exactly as the original part does.
    always_comb begin
        prop_s     = 4'b0000;
        gen_s      = 4'b0000;
        carry_s    = 5'b00000;
        f          = 4'b0000;
        carry_s[0] = ~cn;
        for (int i = 0; i < 4; i++) begin
            prop_s[i]    = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            gen_s[i]     = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
            carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
            f[i]         = gen_s[i] ^ prop_s[i] ^ (m | carry_s[i]);
        end
        aeb = &f;
        cn4 = ~carry_s[4];
        p_n = ~(&prop_s);
        g_n = ~(gen_s[3]
              | (prop_s[3] & gen_s[2])
              | (prop_s[3] & prop_s[2] & gen_s[1])
              | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]));
    end

endmodule

// File: rtl/alu181_seq.sv
// alu181_seq: WIDTH-bit 74181-style ALU evaluated one nibble per cycle,
// LSB nibble first, through a single shared alu181_slice.
//   clk, rst_n (synchronous, active-low)
//   start       : request, sampled while busy=0
//   s, m, cn    : function select, mode, active-low carry-in
//   a, b        : WIDTH-bit operands, latched on the accepting edge
//   busy, done  : handshake; done pulses one cycle when results are valid
//   f, aeb, cn4, p_n, g_n : registered results, held from done to next done
module alu181_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             aeb,
    output logic             cn4,
    output logic             p_n,
    output logic             g_n
);

    import alu181_pkg::*;

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t           state_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       s_r;
    logic             m_r;
    logic             carry_n_r;  // active-low carry into the current nibble
    logic             p_acc_n_r;
    logic             g_acc_n_r;
    logic             aeb_acc_r;  // AND of slice aeb over nibbles written so far

    logic             accept_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [WIDTH-1:0] f_next_s;
    logic [3:0]       sl_f_s;
    logic             sl_aeb_s;
    logic             sl_cn4_s;
    logic             sl_p_n_s;
    logic             sl_g_n_s;

    alu181_slice u_slice (
        .a   (a_nib_s),
        .b   (b_nib_s),
        .s   (s_r),
        .m   (m_r),
        .cn  (carry_n_r),
        .f   (sl_f_s),
        .aeb (sl_aeb_s),
        .cn4 (sl_cn4_s),
        .p_n (sl_p_n_s),
        .g_n (sl_g_n_s)
    );

    // A request is taken in IDLE and also in DONE, giving back-to-back issue.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            DONE:    accept_s = start;
            default: accept_s = 1'b0;
        endcase
    end

    // Select operand nibble k and merge the slice result into nibble k of f.
    always_comb begin
        a_nib_s  = 4'b0000;
        b_nib_s  = 4'b0000;
        f_next_s = f;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_r == KW'(i)) begin
                a_nib_s                     = a_r[i*SLICE_W +: SLICE_W];
                b_nib_s                     = b_r[i*SLICE_W +: SLICE_W];
                f_next_s[i*SLICE_W +: SLICE_W] = sl_f_s;
            end else begin
                f_next_s[i*SLICE_W +: SLICE_W] = f[i*SLICE_W +: SLICE_W];
            end
        end
    end

    // Controller FSM with operand/carry/accumulator registers and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            k_r       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            s_r       <= 4'b0000;
            m_r       <= 1'b0;
            carry_n_r <= 1'b1;
            p_acc_n_r <= 1'b0;
            g_acc_n_r <= 1'b1;
            aeb_acc_r <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            f         <= '0;
            aeb       <= 1'b0;
            cn4       <= 1'b1;
            p_n       <= 1'b1;
            g_n       <= 1'b1;
        end else if (accept_s) begin
            state_r   <= RUN;
            k_r       <= '0;
            a_r       <= a;
            b_r       <= b;
            s_r       <= s;
            m_r       <= m;
            carry_n_r <= cn;
            p_acc_n_r <= 1'b0;
            g_acc_n_r <= 1'b1;
            aeb_acc_r <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                end
                RUN: begin
                    f         <= f_next_s;
                    carry_n_r <= sl_cn4_s;
                    p_acc_n_r <= p_acc_n_r | sl_p_n_s;
                    g_acc_n_r <= g_merge_n(sl_g_n_s, sl_p_n_s, g_acc_n_r);
                    aeb_acc_r <= aeb_acc_r & sl_aeb_s;
                    k_r       <= k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // every nibble is rewritten per operation, so the
                        // AND of slice aeb flags equals &f_final
                        aeb     <= aeb_acc_r & sl_aeb_s;
                        cn4     <= sl_cn4_s;
                        p_n     <= p_acc_n_r | sl_p_n_s;
                        g_n     <= g_merge_n(sl_g_n_s, sl_p_n_s, g_acc_n_r);
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu181_seq.md
# alu181_seq

Parametrised, multi-cycle successor to the 4-bit 74181-style ALU. It evaluates a WIDTH-bit operation by stepping one combinational 74181-equivalent slice across WIDTH/4 nibbles, LSB nibble first, rippling the carry through a register between cycles. A start/busy/done handshake lets a datapath controller issue wide ALU operations without instantiating WIDTH/4 parallel slices. Function table (S, M, Cn semantics, active-high data) is identical to the 4-bit part.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- s  in  4  function select, 74181 encoding.
- m  in  1  mode: 1 = logic, 0 = arithmetic.
- cn  in  1  carry-in, active-low (1 = no carry).
- a, b  in  WIDTH  operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- f  out  WIDTH  result.
- aeb  out  1  high when f is all ones.
- cn4  out  1  carry-out of the MSB nibble, active-low.
- p_n  out  1  group propagate, active-low.
- g_n  out  1  group generate, active-low.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b, s, m, cn into operand registers, clears slice counter k to 0, loads the carry register with cn, sets p_acc_n=0 and g_acc_n=1, and moves to RUN. busy rises.
- RUN, each cycle: the slice computes nibble k from a[4k+3:4k], b[4k+3:4k], s, m, and the carry register. F nibble k is written into f, the carry register takes the slice Cn+4, p_acc_n |= slice P_n, and g_acc_n = slice G_n & (slice P_n | g_acc_n). k increments.
- After nibble NSLICE-1 is written, move to DONE. In the same edge, cn4, p_n, and g_n take their final values, and aeb = &f_final.
- DONE lasts one cycle: done=1, busy=0. It goes to IDLE, or straight to RUN if start=1, which latches new operands.
- f, aeb, cn4, p_n, and g_n hold their values from done until the next done. Intermediate nibbles may update f during RUN, so consumers must sample on done only.
- In logic mode (m=1), the carry chain still runs and cn4, p_n, and g_n are still reported, but f is independent of carry, matching the slice.
- start while busy=1 is ignored. No queueing is done and no error is flagged.
- Reset values: busy=0, done=0, f=0, aeb=0, cn4=1, p_n=1, g_n=1, state=IDLE, k=0.
- rst_n=0 during RUN aborts the operation. The next edge applies the reset values and the partial result is discarded.

## Timing
- Start accepted at edge 0 gives busy=1 from cycle 1 through cycle NSLICE, and done=1 in cycle NSLICE+1.
- Total latency from start to done is NSLICE+1 cycles. For WIDTH=16 this is 5 cycles; for WIDTH=4 it is 2 cycles.
- Back-to-back throughput is one operation per NSLICE+1 cycles, with start asserted during the done cycle.
- Operand inputs only need to be valid on the accepting edge. Changes afterwards have no effect.
- All outputs are registered, so there is no combinational input-to-output path.

## Structure
- Package alu181_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - SLICE_W = 4
  - named S codes: S_ADD = 4'b1001, S_SUB = 4'b0110, S_XOR = 4'b0110 with m=1, S_AND = 4'b1011, S_OR = 4'b1110
- Sub-module alu181_slice: purely combinational 4-bit 74181 equivalent.
  - Inputs: a, b, s, m, cn. Outputs: f, aeb, cn4, p_n, g_n.
  - Instantiated once and shared across cycles.
- Top level contains the FSM, the ceil-log2(NSLICE)-bit counter k, the operand, carry, and accumulator registers, and nibble write-back into f.

## Test plan
- WIDTH=16, s=1001, m=0, cn=1, a=0x1234, b=0x0FFF, start pulse: done in cycle 5, f=0x2233, cn4=1, aeb=0.
- s=1001, m=0, cn=1, a=0xFFFF, b=0x0001: f=0x0000, cn4=0 (carry ripples through all four nibbles).
- s=0110, m=0, cn=0, a=0x5000, b=0x1234: f=0x3DCC, cn4=0. Then cn=1, a=b=0xABCD: f=0xFFFF, aeb=1.
- s=0110, m=1, a=0xF0F0, b=0xFF00, cn toggled between runs: f=0x0FF0 both times.
- Handshake:
  - start held high through busy: a new operation is taken only on the done cycle.
  - start pulsed mid-RUN with different operands: ignored, and the original result is produced.
- rst_n=0 in the third RUN cycle: the next cycle shows busy=0, done=0, f=0, cn4=1, p_n=1, g_n=1. A fresh start afterwards gives the correct result.
